// File: rtl/bt_dir_rx.sv
// Purpose : 8N1 UART receiver for the Bluetooth module TX line; decodes L/U/D/R/S (either case) into a one-hot direction.
// Latency : data_valid about CLKS_PER_BIT*9.5 + 3 clocks after the start-bit falling edge at get.
// Backpr. : none; data_valid is a single-cycle pulse and the consumer must take data_out/dir on that cycle.
//
// Ports:
//    clk        system clock, rising edge
//    rst        asynchronous active-low reset
//    get        serial RX line (idles high, asynchronous to clk)
//    dir        registered one-hot direction [3]=left [2]=up [1]=down [0]=right, 0 = stop
//    data_out   last correctly framed byte
//    data_valid one-cycle pulse when data_out updates
//
// Optional build macro DIR_TIMEOUT_EN: forces dir to 0 after TIMEOUT_CYCLES clocks with no valid frame.

module bt_dir_rx #(
   parameter int CLK_FREQ       = 100_000_000,
   parameter int BAUD           = 9600,
   parameter int CLKS_PER_BIT   = CLK_FREQ / BAUD,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       get,
   output logic [3:0] dir,
   output logic [7:0] data_out,
   output logic       data_valid
);

   // The half-bit wait in START needs at least two clocks per bit.
   if (CLKS_PER_BIT < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("bt_dir_rx: CLKS_PER_BIT must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t        state;
   logic          rx_m;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   // Set for one cycle after a good stop bit; outputs commit on the following clock.
   logic          frame_ok;
   logic          cmd_hit;
   logic [3:0]    cmd_dir;

   // Clearing bit 5 folds lowercase letters onto uppercase; no other byte aliases a command.
   always_comb begin
      cmd_hit = 1'b1;
      cmd_dir = 4'b0000;
      case (shreg & 8'hDF)
         8'h4C:   cmd_dir = 4'b1000;
         8'h55:   cmd_dir = 4'b0100;
         8'h44:   cmd_dir = 4'b0010;
         8'h52:   cmd_dir = 4'b0001;
         8'h53:   cmd_dir = 4'b0000;
         default: cmd_hit = 1'b0;
      endcase
   end

`ifdef DIR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt;

   // Saturating inactivity counter, restarted by every valid frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (frame_ok) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         frame_ok   <= 1'b0;
         dir        <= 4'b0000;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
      end else begin
         rx_m       <= get;
         rx_s       <= rx_m;
         data_valid <= 1'b0;
         frame_ok   <= 1'b0;

         if (frame_ok) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
            if (cmd_hit) dir <= cmd_dir;
         end
`ifdef DIR_TIMEOUT_EN
         else if (tmo_cnt == TMO_MAX) begin
            dir <= 4'b0000;
         end
`endif

         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_cnt <= '0;
               if (!rx_s) state <= START;
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  // A high line at mid start bit is a glitch, not a frame.
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  if (bit_cnt == 3'd7) state <= STOP;
                  else bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     frame_ok <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     // Framing error or break: drop the byte and wait for the line to recover.
                     state <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bt_dir_rx.sv
// Purpose : directed self-checking bench for bt_dir_rx at 16 clocks per bit.
// Latency : checks the data_valid delay from the start-bit edge against 9.5*16+3 clocks (+-1 plus edge phase).
// Backpr. : none.

module tb_bt_dir_rx;

   localparam int C = 16;

   logic       clk;
   logic       rst;
   logic       get;
   logic [3:0] dir;
   logic [7:0] data_out;
   logic       data_valid;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dv_count = 0;
   int dv_cyc = 0;
   int t0 = 0;
   int base = 0;
   logic [7:0] last_data = 8'h00;

   bt_dir_rx #(
      .CLK_FREQ       (1_600_000),
      .BAUD           (100_000),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .get        (get),
      .dir        (dir),
      .data_out   (data_out),
      .data_valid (data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every high cycle of data_valid counts, so a stretched pulse shows as an extra byte.
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         dv_count  = dv_count + 1;
         last_data = data_out;
         dv_cyc    = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start bit, nbits data bits LSB first, then the stop bit only for a full byte.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
      get = 1'b0;
      t0  = cyc;
      repeat (C) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         get = b[i];
         repeat (C) @(negedge clk);
      end
      if (nbits == 8) begin
         get = stop_bit;
         repeat (C) @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1, 8);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      get = 1'b1;

      // Reset held with a toggling line.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         get = ~get;
      end
      chk("reset_dir", 32'(dir), 32'h0);
      chk("reset_data", 32'(data_out), 32'h00);
      chk("reset_no_valid", 32'(dv_count), 32'd0);

      get = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (20 * C) @(negedge clk);
      chk("idle_dir", 32'(dir), 32'h0);
      chk("idle_data", 32'(data_out), 32'h00);
      chk("idle_no_valid", 32'(dv_count), 32'd0);

      // 'L', including the start-edge to data_valid delay.
      send_byte(8'h4C);
      chk("L_pulses", 32'(dv_count), 32'd1);
      chk("L_data", 32'(last_data), 32'h4C);
      chk("L_dir", 32'(dir), 32'b1000);
      chk("L_latency_ok", 32'((dv_cyc - t0) >= 154 && (dv_cyc - t0) <= 157), 32'd1);

      send_byte(8'h52);
      chk("R_dir", 32'(dir), 32'b0001);
      chk("R_pulses", 32'(dv_count), 32'd2);

      send_byte(8'h73);
      chk("s_dir", 32'(dir), 32'b0000);
      chk("s_data", 32'(data_out), 32'h73);

      send_byte(8'h52);
      send_byte(8'h41);
      chk("A_pulses", 32'(dv_count), 32'd5);
      chk("A_data", 32'(data_out), 32'h41);
      chk("A_dir_hold", 32'(dir), 32'b0001);

      // Short low glitch must not start a frame.
      base = dv_count;
      get = 1'b0;
      repeat (C / 4) @(negedge clk);
      get = 1'b1;
      repeat (2 * C) @(negedge clk);
      chk("glitch_no_valid", 32'(dv_count), 32'(base));
      send_byte(8'h55);
      chk("U_after_glitch_dir", 32'(dir), 32'b0100);
      chk("U_after_glitch_pulses", 32'(dv_count), 32'(base + 1));

      // Framing error followed by a held-low line, then a good 'D'.
      base = dv_count;
      send_frame(8'h44, 1'b0, 8);
      repeat (3 * C) @(negedge clk);
      get = 1'b1;
      repeat (C) @(negedge clk);
      chk("ferr_no_valid", 32'(dv_count), 32'(base));
      chk("ferr_dir_hold", 32'(dir), 32'b0100);
      send_byte(8'h44);
      chk("D_pulses", 32'(dv_count), 32'(base + 1));
      chk("D_dir", 32'(dir), 32'b0010);
      chk("D_data", 32'(data_out), 32'h44);

      // Back-to-back lowercase frames with no idle gap.
      base = dv_count;
      send_frame(8'h6C, 1'b1, 8);
      send_frame(8'h75, 1'b1, 8);
      repeat (2) @(negedge clk);
      chk("b2b_pulses", 32'(dv_count), 32'(base + 2));
      chk("b2b_data", 32'(data_out), 32'h75);
      chk("b2b_dir", 32'(dir), 32'b0100);

      // Reset in the middle of data bit 4.
      base = dv_count;
      send_frame(8'h44, 1'b1, 4);
      get = 1'b0;
      repeat (C / 2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_dir", 32'(dir), 32'h0);
      chk("midrst_data", 32'(data_out), 32'h00);
      chk("midrst_valid", 32'(data_valid), 32'd0);
      get = 1'b1;
      rst = 1'b1;
      repeat (2 * C) @(negedge clk);
      chk("midrst_no_valid", 32'(dv_count), 32'(base));
      send_byte(8'h4C);
      chk("post_rst_dir", 32'(dir), 32'b1000);
      chk("post_rst_data", 32'(data_out), 32'h4C);

      // Inactivity behaviour after the last valid frame.
      repeat (800) @(negedge clk);
      chk("tmo_early_dir", 32'(dir), 32'b1000);
      repeat (400) @(negedge clk);
`ifdef DIR_TIMEOUT_EN
      chk("tmo_dir_stop", 32'(dir), 32'b0000);
`else
      chk("no_tmo_dir_hold", 32'(dir), 32'b1000);
`endif
      chk("tmo_no_valid", 32'(dv_count), 32'(base + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
